seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Multiplexed three-digit seven-segment display driver. It sits directly downstream of the binary-to-BCD converter and takes its hundreds, tens and units nibbles through a valid/ready handshake. It shadows each accepted value and commits it only at a scan-frame boundary, so the display never shows a torn number. It then time-multiplexes the digits onto shared segment lines with leading-zero blanking and an out-of-range indicator.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal range ≥ 2.
- ACTIVE_LOW_SEG, 1: 1 means o_seg is active-low (a lit segment drives 0); 0 means active-high.
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  upstream holds a BCD value on i_hunds/i_tens/i_units.
- i_hunds  in  4  BCD hundreds digit.
- i_tens  in  4  BCD tens digit.
- i_units  in  4  BCD units digit.
- o_ready  out  1  block can accept a value; a transfer occurs when i_valid && o_ready.
- o_an  out  3  digit enables, active-low, one-hot: bit0 = units, bit1 = tens, bit2 = hunds.
- o_seg  out  7  segments, ordered {g,f,e,d,c,b,a}.
- o_err  out  1  the committed value contains a nibble greater than 9.

## Operation
- State:
  - refresh counter cnt, 0..REFRESH_DIV-1.
  - digit index dig, 0..2.
  - pending register plus pend_full flag.
  - committed display registers disp_h, disp_t, disp_u.
- Accept:
  - When i_valid && o_ready, the three nibbles are captured into the pending register and pend_full is set.
  - o_ready = !pend_full.
  - i_valid while o_ready is low is ignored; upstream must hold its data until it sees ready.
- Scan:
  - cnt increments every cycle.
  - At cnt == REFRESH_DIV-1, cnt wraps to 0 and dig advances 0→1→2→0.
- Commit:
  - Occurs in the cycle where cnt == REFRESH_DIV-1 and dig == 2 (end of frame).
  - If pend_full, pending is copied into disp_* and pend_full clears.
  - If pend_full is clear, disp_* is unchanged.
  - An accept cannot coincide with a commit, because o_ready is low whenever pend_full is set.
- Blanking:
  - Hundreds is blank when disp_h == 0.
  - Tens is blank when disp_h == 0 and disp_t == 0.
  - Units is never blank.
  - A blanked digit keeps its o_an bit asserted, with all segments off.
- Decode, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Any nibble 10..15 shows a dash, 40.
  - Blank is 00.
  - When ACTIVE_LOW_SEG == 1, the code is bitwise inverted onto o_seg.
- The blanking test uses the raw nibble value, so a nibble > 9 is never blanked and always shows a dash.
- o_err is combinational from disp_*: it is 1 when any of disp_h, disp_t, disp_u is > 9.

## Timing
- Reset, while i_rst_n is sampled low on a rising edge:
  - cnt = 0, dig = 0, pending = 0, pend_full = 0, disp_* = 0.
  - o_ready = 1, o_an = 3'b110, o_seg = 7'h40 (the digit "0", active-low), o_err = 0.
- o_an and o_seg are registered and follow dig/disp_* with one cycle of latency.
- Each digit is lit for exactly REFRESH_DIV cycles; a frame is 3×REFRESH_DIV cycles.
- Accept to o_ready low: the next cycle.
- Commit to new value: the cycle after commit, o_ready returns to 1. One cycle after that, the new units digit appears on o_seg with o_an = 110.
- Worst-case accept-to-display latency is 3×REFRESH_DIV + 1 cycles.
- Reset asserted mid-frame or with a pending value: everything returns to the reset values; the pending value is discarded; scanning restarts at units.

## Test plan
Use REFRESH_DIV = 4 and ACTIVE_LOW_SEG = 1 for all scenarios.
- Reset: hold i_rst_n low for 2 cycles, then release → o_an = 110, o_seg = 40, o_ready = 1, o_err = 0; o_an cycles 110/101/011, each for 4 cycles; both blanked digits show 7F.
- Load 2,5,5 → o_ready low until the frame end. Then units shows 12 for 4 cycles, tens shows 12, hunds shows 24; o_err = 0.
- Load 0,0,7 → hunds and tens show 7F (blank), units shows 78.
- Load 0,1,C → hunds shows 7F, tens shows 79, units shows 3F (dash); o_err = 1 from the commit onward. Then load 0,0,0 → o_err returns to 0.
- Back-to-back: accept 1,2,3, then assert i_valid with 4,5,6 while o_ready = 0 → 1,2,3 is displayed; 4,5,6 is accepted only after o_ready rises.
- Assert reset mid-frame while pend_full = 1 → the reset values return and the pending value never appears on o_seg.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Three-digit multiplexed seven-segment driver with a valid/ready BCD input.
// Values are shadowed and committed only at a frame boundary to avoid torn displays.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [3:0] i_hunds,
  input  logic [3:0] i_tens,
  input  logic [3:0] i_units,
  output logic       o_ready,
  output logic [2:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_err
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [6:0] ResetSeg = ACTIVE_LOW_SEG ? 7'h40 : 7'h3F;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  logic [11:0]     pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [3:0]      disp_h_q, disp_h_d;
  logic [3:0]      disp_t_q, disp_t_d;
  logic [3:0]      disp_u_q, disp_u_d;
  logic [2:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic       last;
  logic       blank;
  logic [3:0] nib;
  logic [6:0] code;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h40;
    endcase
    return c;
  endfunction

  always_comb begin
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_h_d    = disp_h_q;
    disp_t_d    = disp_t_q;
    disp_u_d    = disp_u_q;
    last        = (cnt_q == CntLast);

    // Accept and commit are mutually exclusive: commit needs pend_full, accept needs it clear.
    if (i_valid && !pend_full_q) begin
      pend_d      = {i_hunds, i_tens, i_units};
      pend_full_d = 1'b1;
    end

    if (last) begin
      cnt_d = '0;
      if (dig_q == 2'd2) begin
        dig_d = 2'd0;
        if (pend_full_q) begin
          disp_h_d    = pend_q[11:8];
          disp_t_d    = pend_q[7:4];
          disp_u_d    = pend_q[3:0];
          pend_full_d = 1'b0;
        end
      end else begin
        dig_d = dig_q + 2'd1;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Blanking compares raw nibbles, so an out-of-range nibble always shows a dash.
  always_comb begin
    nib   = disp_u_q;
    blank = 1'b0;
    an_d  = 3'b110;
    case (dig_q)
      2'd0: begin
        nib   = disp_u_q;
        blank = 1'b0;
        an_d  = 3'b110;
      end
      2'd1: begin
        nib   = disp_t_q;
        blank = (disp_h_q == 4'd0) && (disp_t_q == 4'd0);
        an_d  = 3'b101;
      end
      default: begin
        nib   = disp_h_q;
        blank = (disp_h_q == 4'd0);
        an_d  = 3'b011;
      end
    endcase
    code  = blank ? 7'h00 : decode(nib);
    seg_d = ACTIVE_LOW_SEG ? ~code : code;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      dig_q       <= 2'd0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_h_q    <= 4'd0;
      disp_t_q    <= 4'd0;
      disp_u_q    <= 4'd0;
      an_q        <= 3'b110;
      seg_q       <= ResetSeg;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_h_q    <= disp_h_d;
      disp_t_q    <= disp_t_d;
      disp_u_q    <= disp_u_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign o_ready = !pend_full_q;
  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_err   = (disp_h_q > 4'd9) || (disp_t_q > 4'd9) || (disp_u_q > 4'd9);

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV = 4 and active-low segments.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] hunds = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] units = 4'd0;
  logic       ready;
  logic [2:0] an;
  logic [6:0] seg;
  logic       err;

  int total = 0;
  int bad = 0;

  seven_seg_scan #(
    .REFRESH_DIV   (4),
    .ACTIVE_LOW_SEG(1'b1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .i_hunds(hunds),
    .i_tens (tens),
    .i_units(units),
    .o_ready(ready),
    .o_an   (an),
    .o_seg  (seg),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples k = first_k..12 after successive edges; digit index is (k-1)/4.
  task automatic check_frame(input int first_k, input logic [6:0] su, input logic [6:0] st,
                             input logic [6:0] sh, input logic exp_err, input string nm);
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    for (int k = first_k; k <= 12; k++) begin
      tick();
      case ((k - 1) / 4)
        0:       begin exp_an = 3'b110; exp_seg = su; end
        1:       begin exp_an = 3'b101; exp_seg = st; end
        default: begin exp_an = 3'b011; exp_seg = sh; end
      endcase
      total++;
      if (an !== exp_an || seg !== exp_seg) begin
        bad++;
        $display("FAIL %s_scan k=%0d: an=%b seg=%h, expected an=%b seg=%h",
                 nm, k, an, seg, exp_an, exp_seg);
      end
      total++;
      if (err !== exp_err) begin
        bad++;
        $display("FAIL %s_err k=%0d: err=%b, expected %b", nm, k, err, exp_err);
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    total++;
    if (an !== 3'b110 || seg !== 7'h40 || ready !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s: an=%b seg=%h ready=%b err=%b, expected an=110 seg=40 ready=1 err=0",
               nm, an, seg, ready, err);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 14) begin
      tick();
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_wait_ready: ready=%b after %0d cycles, expected 1", nm, ready, n);
    end
  endtask

  task automatic load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                      input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh,
                      input logic exp_err, input string nm);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_pre: ready=%b, expected 1", nm, ready);
    end
    valid = 1'b1;
    hunds = h;
    tens  = t;
    units = u;
    tick();
    valid = 1'b0;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_low: ready=%b, expected 0", nm, ready);
    end
    wait_ready(nm);
    // Cycle after the commit: err already reflects the new value, hunds slot still lit.
    total++;
    if (err !== exp_err) begin
      bad++;
      $display("FAIL %s_err_commit: err=%b, expected %b", nm, err, exp_err);
    end
    total++;
    if (an !== 3'b011) begin
      bad++;
      $display("FAIL %s_an_commit: an=%b, expected 011", nm, an);
    end
    check_frame(1, su, st, sh, exp_err, nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    check_frame(1, 7'h40, 7'h7F, 7'h7F, 1'b0, "reset");
  endtask

  task automatic test_load_255();
    load(4'd2, 4'd5, 4'd5, 7'h12, 7'h12, 7'h24, 1'b0, "load255");
  endtask

  task automatic test_blanking();
    load(4'd0, 4'd0, 4'd7, 7'h78, 7'h7F, 7'h7F, 1'b0, "blank007");
  endtask

  task automatic test_dash_err();
    load(4'd0, 4'd1, 4'hC, 7'h3F, 7'h79, 7'h7F, 1'b1, "dash01c");
    load(4'd0, 4'd0, 4'd0, 7'h40, 7'h7F, 7'h7F, 1'b0, "clear000");
  endtask

  task automatic test_back_to_back();
    valid = 1'b1;
    hunds = 4'd1;
    tens  = 4'd2;
    units = 4'd3;
    tick();
    hunds = 4'd4;
    tens  = 4'd5;
    units = 4'd6;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready_low: ready=%b, expected 0", ready);
    end
    wait_ready("b2b_first");
    tick();
    total++;
    if (ready !== 1'b0 || an !== 3'b110 || seg !== 7'h30) begin
      bad++;
      $display("FAIL b2b_second_accept: ready=%b an=%b seg=%h, expected ready=0 an=110 seg=30",
               ready, an, seg);
    end
    valid = 1'b0;
    check_frame(2, 7'h30, 7'h24, 7'h79, 1'b0, "b2b_123");
    wait_ready("b2b_second");
    check_frame(1, 7'h02, 7'h12, 7'h19, 1'b0, "b2b_456");
  endtask

  task automatic test_reset_mid();
    valid = 1'b1;
    hunds = 4'd9;
    tens  = 4'd8;
    units = 4'd7;
    tick();
    valid = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pending: ready=%b, expected 0", ready);
    end
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("rstmid_vals");
    rst_n = 1'b1;
    check_frame(1, 7'h40, 7'h7F, 7'h7F, 1'b0, "rstmid_f1");
    check_frame(1, 7'h40, 7'h7F, 7'h7F, 1'b0, "rstmid_f2");
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready: ready=%b, expected 1", ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_255();
    test_blanking();
    test_dash_err();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
